// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability-counter debounce,
// press/release/long-press pulses and a wrapping press counter.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [23:0] LONG_CYCLES     = 24'd10000000,
  parameter logic        ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic [7:0] press_cnt
);

  localparam logic [19:0] DbLast   = DEBOUNCE_CYCLES - 20'd1;
  localparam logic [23:0] HoldLast = LONG_CYCLES - 24'd1;

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        long_done_q, long_done_d;
  logic [23:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  press_cnt_q, press_cnt_d;
  logic        key_r;

  always_comb begin
    s1_d  = key_in;
    s2_d  = s1_q;
    key_r = s2_q ^ ACTIVE_LOW;

    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any return to the accepted level restarts the stability window.
    if (key_r == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DbLast) begin
      db_cnt_d = db_cnt_q + 20'd1;
    end else begin
      db_cnt_d  = '0;
      level_d   = key_r;
      press_d   = key_r;
      release_d = ~key_r;
    end

    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (!level_q) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (!long_done_q) begin
      if (hold_cnt_q == HoldLast) begin
        // A release accepted this cycle wins so pulses never overlap.
        long_d      = ~release_d;
        long_done_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 24'd1;
      end
    end

    press_cnt_d = press_cnt_q + {7'd0, press_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= ACTIVE_LOW;
      s2_q        <= ACTIVE_LOW;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
      hold_cnt_q  <= '0;
      press_cnt_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      long_done_q <= long_done_d;
      hold_cnt_q  <= hold_cnt_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign press_cnt   = press_cnt_q;

endmodule
